// File: rtl/idelay_tap_loader.sv
// Runtime tap programmer for a bank of VAR_LOAD IDELAYE2 lanes: converts a
// picosecond request to taps, pulses LD on the target lane, settles, reports.
module idelay_tap_loader #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned CAL_FREQ      = 200,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LANE_BITS     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   idelayctrl_rdy,
    input  logic                   req_en,
    input  logic [LANE_BITS-1:0]   req_lane,
    input  logic [15:0]            req_delay_ps,
    output logic                   req_ready,
    output logic                   done,
    output logic [1:0]             done_status,
    output logic [4:0]             done_taps,
    output logic [WIDTH-1:0]       tap_ld,
    output logic [4:0]             tap_cnt_in,
    output logic [WIDTH*5-1:0]     lane_taps
);

    localparam int unsigned TAP_W    = 5;
    localparam logic [15:0] TAP_SIZE = (CAL_FREQ == 400) ? 16'd39 : 16'd78;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_RANGE = 2'd1;
    localparam logic [1:0] ST_NRDY  = 2'd2;
    localparam logic [1:0] ST_LANE  = 2'd3;

    generate
        if (CAL_FREQ != 200 && CAL_FREQ != 400) begin : g_bad_cal
            $fatal(1, "idelay_tap_loader: CAL_FREQ must be 200 or 400");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $fatal(1, "idelay_tap_loader: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, DIVIDE, LOAD, SETTLE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [LANE_BITS-1:0]   lane, lane_nxt;
    logic [15:0]            rem, rem_nxt;
    logic [TAP_W-1:0]       cnt, cnt_nxt;
    logic [SETTLE_W-1:0]    settle_cnt, settle_nxt;
    logic [WIDTH-1:0]       tap_ld_nxt;
    logic [TAP_W-1:0]       tap_cnt_nxt;
    logic                   done_nxt;
    logic [1:0]             status_nxt;
    logic [TAP_W-1:0]       done_taps_nxt;
    logic [WIDTH*5-1:0]     lane_taps_nxt;

    // Only IDLE accepts, and only while the delay controller is calibrated.
    assign req_ready = (state == IDLE) && idelayctrl_rdy;

    // Next-state and next-output logic; every output below is registered.
    always_comb begin
        state_nxt     = state;
        lane_nxt      = lane;
        rem_nxt       = rem;
        cnt_nxt       = cnt;
        settle_nxt    = settle_cnt;
        tap_ld_nxt    = '0;
        tap_cnt_nxt   = tap_cnt_in;
        done_nxt      = 1'b0;
        status_nxt    = done_status;
        done_taps_nxt = done_taps;
        lane_taps_nxt = lane_taps;

        case (state)
            IDLE: begin
                if (req_en && idelayctrl_rdy) begin
                    lane_nxt = req_lane;
                    rem_nxt  = req_delay_ps;
                    cnt_nxt  = '0;
                    if (32'(req_lane) >= WIDTH) begin
                        state_nxt     = DONE;
                        done_nxt      = 1'b1;
                        status_nxt    = ST_LANE;
                        done_taps_nxt = '0;
                    end else begin
                        state_nxt = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (!idelayctrl_rdy) begin
                    state_nxt     = DONE;
                    done_nxt      = 1'b1;
                    status_nxt    = ST_NRDY;
                    done_taps_nxt = '0;
                end else if (rem >= TAP_SIZE) begin
                    // A 32nd subtraction would overflow the 5-bit tap field.
                    if (cnt == 5'd31) begin
                        state_nxt     = DONE;
                        done_nxt      = 1'b1;
                        status_nxt    = ST_RANGE;
                        done_taps_nxt = '0;
                    end else begin
                        rem_nxt = rem - TAP_SIZE;
                        cnt_nxt = cnt + 5'd1;
                    end
                end else begin
                    state_nxt   = LOAD;
                    tap_cnt_nxt = cnt;
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        if (lane == LANE_BITS'(i)) tap_ld_nxt[i] = 1'b1;
                    end
                end
            end
            LOAD: begin
                // The LD pulse is on the pins this cycle, so the shadow copy updates
                // even if the controller drops ready now.
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (lane == LANE_BITS'(i)) lane_taps_nxt[i*TAP_W +: TAP_W] = cnt;
                end
                if (!idelayctrl_rdy) begin
                    state_nxt     = DONE;
                    done_nxt      = 1'b1;
                    status_nxt    = ST_NRDY;
                    done_taps_nxt = '0;
                end else begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                if (!idelayctrl_rdy) begin
                    state_nxt     = DONE;
                    done_nxt      = 1'b1;
                    status_nxt    = ST_NRDY;
                    done_taps_nxt = '0;
                end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt     = DONE;
                    done_nxt      = 1'b1;
                    status_nxt    = ST_OK;
                    done_taps_nxt = cnt;
                end else begin
                    settle_nxt = settle_cnt + SETTLE_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lane        <= '0;
            rem         <= '0;
            cnt         <= '0;
            settle_cnt  <= '0;
            tap_ld      <= '0;
            tap_cnt_in  <= '0;
            done        <= 1'b0;
            done_status <= '0;
            done_taps   <= '0;
            lane_taps   <= '0;
        end else begin
            state       <= state_nxt;
            lane        <= lane_nxt;
            rem         <= rem_nxt;
            cnt         <= cnt_nxt;
            settle_cnt  <= settle_nxt;
            tap_ld      <= tap_ld_nxt;
            tap_cnt_in  <= tap_cnt_nxt;
            done        <= done_nxt;
            done_status <= status_nxt;
            done_taps   <= done_taps_nxt;
            lane_taps   <= lane_taps_nxt;
        end
    end

endmodule
